// File: rtl/femto_pkg.sv
// Shared definitions for the instruction-buffer loader and the ibuffer queue.
package femto_pkg;
    localparam int INSTR_W     = 7;
    localparam int DEF_ENTRIES = 6;

    typedef enum logic [1:0] {
        LOAD,
        PAD,
        RUN
    } state_t;
endpackage

// File: rtl/ibuf_loader_if.sv
// Write/read bus between ibuf_loader (master) and ibuffer (slave).
interface ibuf_loader_if;
    import femto_pkg::*;

    logic               wren;
    logic [INSTR_W-1:0] instr_in;
    logic               rden;
    logic [INSTR_W-1:0] instr_out;

    modport master (output wren, output instr_in, output rden, input instr_out);
    modport slave  (input wren, input instr_in, input rden, output instr_out);
endinterface

// File: rtl/ibuffer.sv
// Circular instruction queue with a registered read port; contents survive reset.
module ibuffer
    import femto_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES
) (
    input logic         clk,
    input logic         reset,
    ibuf_loader_if.slave bus
);
    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [PW-1:0] LAST = PW'(ENTRIES - 1);

    logic [INSTR_W-1:0] mem [ENTRIES];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [INSTR_W-1:0] out_q;

    assign bus.instr_out = out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            out_q  <= '0;
        end else begin
            if (bus.wren) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (bus.rden) begin
                out_q  <= mem[rd_ptr];
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wren) begin
            mem[wr_ptr] <= bus.instr_in;
        end
    end
endmodule

// File: rtl/ibuf_loader.sv
// Serial-to-parallel instruction loader: fills the ibuffer, zero-pads partial
// loads, then drains it on consumer steps while flagging which reads are real.
module ibuf_loader
    import femto_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ser_in,
    input  logic          ser_en,
    input  logic          start,
    input  logic          step,
    ibuf_loader_if.master ibuf,
    output logic          instr_valid,
    output logic          busy
);
    localparam int CW = $clog2(ENTRIES + 1);
    localparam int SW = INSTR_W - 1;
    localparam logic [CW-1:0] FULL = CW'(ENTRIES);

    state_t             state, state_n;
    logic [SW-1:0]      shreg, shreg_n;
    logic [2:0]         bit_cnt, bit_cnt_n;
    logic [CW-1:0]      word_cnt, word_cnt_n;
    logic [CW-1:0]      rd_cnt, rd_cnt_n;
    logic [CW-1:0]      real_cnt, real_cnt_n;
    logic [CW-1:0]      words_after;
    logic               wren_q, wren_n;
    logic [INSTR_W-1:0] instr_q, instr_n;
    logic               rden_q, rden_n;
    logic               pend_q, pend_n;
    logic               valid_n;

    assign ibuf.wren     = wren_q;
    assign ibuf.instr_in = instr_q;
    assign ibuf.rden     = rden_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LOAD;
            shreg       <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            rd_cnt      <= '0;
            real_cnt    <= '0;
            wren_q      <= 1'b0;
            instr_q     <= '0;
            rden_q      <= 1'b0;
            pend_q      <= 1'b0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            word_cnt    <= word_cnt_n;
            rd_cnt      <= rd_cnt_n;
            real_cnt    <= real_cnt_n;
            wren_q      <= wren_n;
            instr_q     <= instr_n;
            rden_q      <= rden_n;
            pend_q      <= pend_n;
            instr_valid <= valid_n;
            busy        <= (state_n != LOAD);
        end
    end

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        word_cnt_n  = word_cnt;
        rd_cnt_n    = rd_cnt;
        real_cnt_n  = real_cnt;
        words_after = word_cnt;
        wren_n      = 1'b0;
        instr_n     = '0;
        rden_n      = 1'b0;
        pend_n      = 1'b0;
        valid_n     = rden_q & pend_q;

        case (state)
            LOAD: begin
                if (ser_en) begin
                    shreg_n = {shreg[SW-2:0], ser_in};
                    if (bit_cnt == 3'(SW)) begin
                        wren_n      = 1'b1;
                        instr_n     = {shreg, ser_in};
                        bit_cnt_n   = '0;
                        words_after = word_cnt + 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                word_cnt_n = words_after;
                // A word completing in the same cycle as start is counted before start is judged.
                if (words_after == FULL) begin
                    real_cnt_n = FULL;
                    state_n    = RUN;
                end else if (start && (words_after != '0)) begin
                    real_cnt_n = words_after;
                    bit_cnt_n  = '0;
                    state_n    = PAD;
                end
            end

            PAD: begin
                wren_n     = 1'b1;
                word_cnt_n = word_cnt + 1'b1;
                if (word_cnt + 1'b1 == FULL) begin
                    state_n = RUN;
                end
            end

            RUN: begin
                if (step) begin
                    rden_n   = 1'b1;
                    pend_n   = (rd_cnt < real_cnt);
                    rd_cnt_n = rd_cnt + 1'b1;
                    if (rd_cnt + 1'b1 == FULL) begin
                        state_n    = LOAD;
                        word_cnt_n = '0;
                        rd_cnt_n   = '0;
                        real_cnt_n = '0;
                        shreg_n    = '0;
                    end
                end
            end

            default: begin
                state_n = LOAD;
            end
        endcase
    end
endmodule

// File: tb/tb_ibuf_loader.sv
// Self-checking bench for ibuf_loader driving an ibuffer, with a write/read scoreboard.
module tb_ibuf_loader;
    import femto_pkg::*;

    localparam int N = 6;

    logic clk = 1'b0;
    logic reset;
    logic ser_in;
    logic ser_en;
    logic start;
    logic step;
    logic instr_valid;
    logic busy;

    ibuf_loader_if bus();

    ibuf_loader #(.ENTRIES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_in     (ser_in),
        .ser_en     (ser_en),
        .start      (start),
        .step       (step),
        .ibuf       (bus),
        .instr_valid(instr_valid),
        .busy       (busy)
    );

    ibuffer #(.ENTRIES(N)) u_buf (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] d;
        logic       v;
    } rd_t;

    typedef struct {
        int              nw;
        logic [5:0][6:0] w;
        int              extra;
        bit              start_last;
    } vec_t;

    rd_t        rd_q[$];
    logic [6:0] wr_q[$];
    int errors = 0;
    int checks = 0;
    int wr_count, rd_count, valid_count;
    logic       rden_prev = 1'b0;
    rd_t        mon_r;
    logic [6:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: writes against wr_q, reads (one cycle after rden) against rd_q.
    always @(negedge clk) begin
        if (reset) begin
            rden_prev = 1'b0;
        end else begin
            if (bus.wren) begin
                wr_count++;
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wren: got wren=1 instr_in=0x%0h expected no write", bus.instr_in);
                end else begin
                    mon_e = wr_q.pop_front();
                    chk("instr_in", bus.instr_in, mon_e);
                end
            end else begin
                chk("instr_in_idle", bus.instr_in, 0);
            end
            chk("wren_rden_excl", bus.wren & bus.rden, 0);
            if (instr_valid) valid_count++;
            if (rden_prev) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got instr_out=0x%0h expected no read", bus.instr_out);
                end else begin
                    mon_r = rd_q.pop_front();
                    chk("instr_out", bus.instr_out, mon_r.d);
                    chk("instr_valid", instr_valid, mon_r.v);
                end
            end else begin
                chk("instr_valid_idle", instr_valid, 0);
            end
            if (bus.rden) rd_count++;
            rden_prev = bus.rden;
        end
    end

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ser_in = 1'($urandom_range(0, 1));
            ser_en = 1'b0;
            start  = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input logic st);
        @(posedge clk); #1;
        ser_in = b;
        ser_en = 1'b1;
        start  = st;
    endtask

    task automatic send_word(input logic [6:0] w, input logic st_last);
        for (int i = 6; i >= 0; i--) begin
            if ($urandom_range(0, 3) == 0) drive_idle(1);
            send_bit(w[i], st_last && (i == 0));
        end
        wr_q.push_back(w);
        rd_q.push_back('{d: w, v: 1'b1});
    endtask

    task automatic push_pads(input int n);
        for (int i = 0; i < n; i++) begin
            wr_q.push_back(7'h00);
            rd_q.push_back('{d: 7'h00, v: 1'b0});
        end
    endtask

    task automatic clear_counts();
        wr_count    = 0;
        rd_count    = 0;
        valid_count = 0;
    endtask

    task automatic drain(input int exp_valid);
        int cyc;
        @(posedge clk); #1;
        ser_en = 1'b0;
        start  = 1'b0;
        step   = 1'b1;
        cyc    = 0;
        while ((rd_q.size() != 0 || busy) && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 80) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d reads pending expected 0 within 80 cycles", rd_q.size());
        end
        @(posedge clk); #1;
        step = 1'b0;
        drive_idle(2);
        chk("wren_pulses", wr_count, N);
        chk("rden_pulses", rd_count, N);
        chk("valid_cycles", valid_count, exp_valid);
        chk("busy_after_drain", busy, 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
    endtask

    vec_t vecs[4];

    initial begin
        int cyc;
        reset  = 1'b1;
        ser_in = 1'b0;
        ser_en = 1'b0;
        start  = 1'b0;
        step   = 1'b0;

        vecs[0] = '{nw: 6, w: {7'h66, 7'h55, 7'h44, 7'h33, 7'h22, 7'h11}, extra: 0, start_last: 1'b0};
        vecs[1] = '{nw: 2, w: {7'h00, 7'h00, 7'h00, 7'h00, 7'h01, 7'h7F}, extra: 0, start_last: 1'b0};
        vecs[2] = '{nw: 1, w: {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h2A}, extra: 3, start_last: 1'b0};
        vecs[3] = '{nw: 3, w: {7'h00, 7'h00, 7'h00, 7'h4C, 7'h35, 7'h5A}, extra: 0, start_last: 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_wren", bus.wren, 0);
        chk("rst_rden", bus.rden, 0);
        chk("rst_instr_in", bus.instr_in, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // start with nothing loaded must be ignored
        clear_counts();
        @(posedge clk); #1;
        start = 1'b1;
        drive_idle(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ignored_start_busy", busy, 0);
        end
        chk("ignored_start_wren", wr_count, 0);

        for (int v = 0; v < 4; v++) begin
            clear_counts();
            for (int k = 0; k < vecs[v].nw; k++) begin
                send_word(vecs[v].w[k], vecs[v].start_last && (k == vecs[v].nw - 1));
            end
            for (int e = 0; e < vecs[v].extra; e++) begin
                send_bit(1'($urandom_range(0, 1)), 1'b0);
            end
            if (vecs[v].nw < N) begin
                if (!vecs[v].start_last) begin
                    @(posedge clk); #1;
                    ser_en = 1'b0;
                    start  = 1'b1;
                end
                push_pads(N - vecs[v].nw);
            end
            drive_idle(1);
            drain(vecs[v].nw);
        end

        // reset in the middle of RUN, then a fresh full load must read back cleanly
        clear_counts();
        for (int k = 0; k < N; k++) begin
            send_word(7'($urandom_range(0, 127)), 1'b0);
        end
        drive_idle(1);
        cyc = 0;
        while (!busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrun_busy", busy, 1);
        @(posedge clk); #1;
        step = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_reads", rd_count, 2);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midrun_rst_wren", bus.wren, 0);
        chk("midrun_rst_rden", bus.rden, 0);
        chk("midrun_rst_instr_in", bus.instr_in, 0);
        chk("midrun_rst_valid", instr_valid, 0);
        chk("midrun_rst_busy", busy, 0);
        wr_q.delete();
        rd_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_counts();
        for (int k = 0; k < N; k++) begin
            send_word(7'($urandom_range(0, 127)), 1'b0);
        end
        drive_idle(1);
        drain(N);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
